// File: rtl/cim_bit_deserializer.sv
// cim_bit_deserializer
//   Reassembles LANES bit-serial lanes (LSB first) into parallel words and
//   presents them through a single-entry valid/ready buffer.
//   Frame length is WIDTH bits, or FP_WIDTH bits when InFp is high on the
//   first bit of a frame.
// Ports:
//   clk, RST      clock, synchronous active-high reset
//   SDI           one serial bit per lane, bit i -> lane i
//   SdiValid      SDI carries a valid bit slice this cycle
//   SdiLast       sender end-of-frame marker, qualified by SdiValid
//   InFp          frame length select, sampled on the first bit only
//   DataOut       reassembled words, one per lane
//   DataOutValid  DataOut holds an unconsumed frame
//   DataOutReady  consumer accepts DataOut when high with DataOutValid
//   FrameErr      one-cycle pulse, SdiLast arrived at the wrong bit count
//   Overrun       one-cycle pulse, completed frame dropped (buffer full)
//   BitCount      bits received in the current frame
module cim_bit_deserializer #(
  parameter int unsigned LANES    = 36,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned FP_WIDTH = 3
) (
  input  logic                              clk,
  input  logic                              RST,
  input  logic [0:LANES-1]                  SDI,
  input  logic                              SdiValid,
  input  logic                              SdiLast,
  input  logic                              InFp,
  output logic [0:LANES-1][WIDTH-1:0]       DataOut,
  output logic                              DataOutValid,
  input  logic                              DataOutReady,
  output logic                              FrameErr,
  output logic                              Overrun,
  output logic [2:0]                        BitCount
);

  localparam int unsigned CNT_W    = 3;
  localparam logic [CNT_W-1:0] LAST_INT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_FP  = CNT_W'(FP_WIDTH - 1);

  logic [0:LANES-1][WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]            len_m1;

  logic                        first_bit_c;
  logic [CNT_W-1:0]            cur_last_c;
  logic [0:LANES-1][WIDTH-1:0] shift_nxt_c;
  logic                        complete_c;
  logic                        frame_err_c;
  logic                        accept_c;

  // Next shift contents, completion and error detection for this cycle
  always_comb begin
    first_bit_c = (BitCount == '0);
    // Length comes straight from InFp on the first bit, from the latch after
    cur_last_c  = first_bit_c ? (InFp ? LAST_FP : LAST_INT) : len_m1;
    for (int i = 0; i < int'(LANES); i++) begin
      // Clearing on the first bit keeps bits above the frame length at zero
      shift_nxt_c[i]           = first_bit_c ? '0 : shift_reg[i];
      shift_nxt_c[i][BitCount] = SDI[i];
    end
    complete_c  = SdiValid && (BitCount == cur_last_c);
    frame_err_c = SdiValid && SdiLast && !complete_c;
    accept_c    = complete_c && (!DataOutValid || DataOutReady);
  end

  // Frame assembly, output buffer and status pulses
  always_ff @(posedge clk) begin
    if (RST) begin
      shift_reg    <= '0;
      len_m1       <= '0;
      BitCount     <= '0;
      DataOut      <= '0;
      DataOutValid <= 1'b0;
      FrameErr     <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      FrameErr <= frame_err_c;
      Overrun  <= complete_c && !accept_c;
      if (SdiValid) begin
        shift_reg <= shift_nxt_c;
        if (first_bit_c) begin
          len_m1 <= cur_last_c;
        end
        if (complete_c || frame_err_c) begin
          BitCount <= '0;
        end else begin
          BitCount <= BitCount + CNT_W'(1);
        end
      end
      if (accept_c) begin
        DataOut      <= shift_nxt_c;
        DataOutValid <= 1'b1;
      end else if (DataOutValid && DataOutReady && !complete_c) begin
        DataOutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cim_bit_deserializer.sv
// Directed bench for cim_bit_deserializer: frame-level model plus per-cycle
// compare, with literal checks pinning key expectations.
module tb_cim_bit_deserializer;

  localparam int unsigned LANES = 36;
  typedef logic [0:LANES-1][7:0] word_t;

  logic               clk = 1'b0;
  logic               RST = 1'b1;
  logic [0:LANES-1]   SDI = '0;
  logic               SdiValid = 1'b0;
  logic               SdiLast = 1'b0;
  logic               InFp = 1'b0;
  word_t              DataOut;
  logic               DataOutValid;
  logic               DataOutReady = 1'b0;
  logic               FrameErr;
  logic               Overrun;
  logic [2:0]         BitCount;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  cim_bit_deserializer #(.LANES(LANES), .WIDTH(8), .FP_WIDTH(3)) dut (
    .clk(clk), .RST(RST), .SDI(SDI), .SdiValid(SdiValid), .SdiLast(SdiLast),
    .InFp(InFp), .DataOut(DataOut), .DataOutValid(DataOutValid),
    .DataOutReady(DataOutReady), .FrameErr(FrameErr), .Overrun(Overrun),
    .BitCount(BitCount)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Frame-level reference: collect bit slices, build words when the frame is full
  logic [0:LANES-1] slices[$];
  int    flen = 8;
  bit    m_valid = 1'b0;
  word_t m_out = '0;
  bit    m_ferr = 1'b0;
  bit    m_ovr = 1'b0;

  always @(posedge clk) begin
    bit    done;
    word_t w;
    if (RST) begin
      slices.delete();
      m_valid = 1'b0; m_out = '0; m_ferr = 1'b0; m_ovr = 1'b0; flen = 8;
    end else begin
      done = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      if (SdiValid) begin
        if (slices.size() == 0) flen = InFp ? 3 : 8;
        slices.push_back(SDI);
        if (slices.size() == flen) begin
          w = '0;
          for (int i = 0; i < int'(LANES); i++)
            for (int k = 0; k < flen; k++) w[i][k] = slices[k][i];
          slices.delete();
          done = 1'b1;
        end else if (SdiLast) begin
          slices.delete();
          m_ferr = 1'b1;
        end
      end
      if (done) begin
        if (!m_valid || DataOutReady) begin
          m_out = w; m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && DataOutReady) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    int bad;
    if (chk_en) begin
      chk("data_out_valid", 32'(DataOutValid), 32'(m_valid));
      chk("frame_err", 32'(FrameErr), 32'(m_ferr));
      chk("overrun", 32'(Overrun), 32'(m_ovr));
      chk("bit_count", 32'(BitCount), 32'(slices.size()));
      if (m_valid) begin
        bad = 0;
        for (int i = LANES - 1; i >= 0; i--) if (DataOut[i] !== m_out[i]) bad = i;
        chk($sformatf("data_out lane %0d", bad), 32'(DataOut[bad]), 32'(m_out[bad]));
      end
    end
  end

  task automatic step(input logic v, input logic l, input logic fp, input logic rdy,
                      input logic [0:LANES-1] d);
    SdiValid = v; SdiLast = l; InFp = fp; DataOutReady = rdy; SDI = d;
    @(posedge clk);
    #1;
  endtask

  // Send nbits of frame w; optional gap of gap_len idle cycles after bit gap_at
  task automatic send(input word_t w, input int nbits, input int last_at,
                      input logic fp0, input logic fp_rest, input logic rdy,
                      input logic rdy_last, input int gap_at, input int gap_len);
    logic [0:LANES-1] s;
    for (int k = 0; k < nbits; k++) begin
      for (int i = 0; i < int'(LANES); i++) s[i] = w[i][k];
      step(1'b1, (k == last_at), (k == 0) ? fp0 : fp_rest,
           (k == nbits - 1) ? rdy_last : rdy, s);
      if (k == gap_at)
        for (int g = 0; g < gap_len; g++) step(1'b0, 1'b1, fp_rest, rdy, '1);
    end
  endtask

  function automatic word_t mk(input int mul, input int add);
    word_t w;
    for (int i = 0; i < int'(LANES); i++) w[i] = 8'((i * mul + add) & 255);
    return w;
  endfunction

  initial begin
    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("reset valid", 32'(DataOutValid), 32'd0);
    chk("reset bit_count", 32'(BitCount), 32'd0);
    chk("reset data lane 5", 32'(DataOut[5]), 32'd0);
    RST = 1'b0;

    // Integer frame, lane i = i*7
    send(mk(7, 0), 8, 7, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    chk("int valid", 32'(DataOutValid), 32'd1);
    for (int i = 0; i < int'(LANES); i++)
      chk($sformatf("int lane %0d", i), 32'(DataOut[i]), 32'((i * 7) & 255));
    chk("int frame_err", 32'(FrameErr), 32'd0);
    chk("int overrun", 32'(Overrun), 32'd0);

    // InFp frame 3'b101, then InFp dropped mid-frame (length stays 3)
    send(mk(0, 5), 3, 2, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0);
    chk("fp lane 0", 32'(DataOut[0]), 32'h05);
    chk("fp lane 35", 32'(DataOut[35]), 32'h05);
    send(mk(0, 3), 3, -1, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0);
    chk("fp switch valid", 32'(DataOutValid), 32'd1);
    chk("fp switch lane 7", 32'(DataOut[7]), 32'h03);
    chk("fp switch bit_count", 32'(BitCount), 32'd0);

    // Gap after bit 3, then back-to-back second frame
    send(mk(3, 8'h11), 8, 7, 1'b0, 1'b0, 1'b1, 1'b1, 3, 2);
    chk("gap lane 1", 32'(DataOut[1]), 32'h14);
    send(mk(5, 8'h80), 8, 7, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    chk("b2b lane 1", 32'(DataOut[1]), 32'h85);

    // Backpressure: A held, B dropped, C accepted on its completing edge
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    send(mk(1, 8'hA0), 8, 7, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    chk("bp A lane 0", 32'(DataOut[0]), 32'hA0);
    send(mk(2, 8'h40), 8, 7, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    chk("bp B overrun", 32'(Overrun), 32'd1);
    chk("bp B keeps A", 32'(DataOut[2]), 32'hA2);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("bp overrun one cycle", 32'(Overrun), 32'd0);
    send(mk(11, 8'h07), 8, 7, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    chk("bp C overrun", 32'(Overrun), 32'd0);
    chk("bp C lane 1", 32'(DataOut[1]), 32'h12);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Framing error on bit 4, then a clean frame
    send(mk(13, 1), 5, 4, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    chk("ferr pulse", 32'(FrameErr), 32'd1);
    chk("ferr bit_count", 32'(BitCount), 32'd0);
    chk("ferr valid", 32'(DataOutValid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("ferr one cycle", 32'(FrameErr), 32'd0);
    send(mk(17, 9), 8, 7, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    chk("post ferr lane 2", 32'(DataOut[2]), 32'd43);

    // Reset mid-frame, then a fresh frame
    send(mk(19, 2), 5, -1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    RST = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, '1);
    chk("rst valid", 32'(DataOutValid), 32'd0);
    chk("rst bit_count", 32'(BitCount), 32'd0);
    chk("rst data lane 3", 32'(DataOut[3]), 32'd0);
    chk("rst frame_err", 32'(FrameErr), 32'd0);
    RST = 1'b0;
    send(mk(23, 8'h55), 8, 7, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    chk("post rst lane 1", 32'(DataOut[1]), 32'h6C);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
